// File: rtl/ps2_led_sequencer_if.sv
// ps2_led_sequencer_if
// Connects the LED sequencer to the ps2k driver. It carries the receive
// read port and the transmit request/response signals.
//   rx_dsr   : ps2k has a received byte waiting
//   rx_q     : received byte, valid 2 cycles after an rx_rden pulse
//   rx_rden  : one-cycle read enable into ps2k
//   tx_data  : byte to transmit
//   tx_start : one-cycle transmit request
//   tx_done  : one-cycle pulse, byte sent
//   tx_err   : one-cycle pulse, transmit failed
// The master modport is the sequencer side. The slave modport is the ps2k side.
interface ps2_led_sequencer_if;
   logic       rx_dsr;
   logic [7:0] rx_q;
   logic       rx_rden;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done;
   logic       tx_err;

   modport master (
      input  rx_dsr, rx_q, tx_done, tx_err,
      output rx_rden, tx_data, tx_start
   );

   modport slave (
      input  rx_rden, tx_data, tx_start,
      output rx_dsr, rx_q, tx_done, tx_err
   );
endinterface

// File: rtl/ps2_led_sequencer.sv
// ps2_led_sequencer
// This block keeps the PS/2 keyboard LEDs in step with the requested LED state.
// It sends the ED + argument command pair and consumes the ACK (FA) and
// RESEND (FE) replies. While a transaction runs, it takes the shared ps2k
// receive port away from the matrix logic, so reply bytes never reach the matrix.
//   clkk     : system clock
//   reset    : synchronous, active-high reset
//   leds     : requested LEDs, [0] Scroll, [1] Num, [2] Caps
//   ext_rden : read enable from the matrix logic
//   ext_dsr  : byte-available indication to the matrix logic
//   busy     : transaction in progress
//   error    : sticky, set when the last transaction failed
//   ps2      : ps2k receive/transmit port (master side)
module ps2_led_sequencer #(
   parameter int TIMEOUT   = 600000,
   parameter int MAX_RETRY = 3
) (
   input  logic                       clkk,
   input  logic                       reset,
   input  logic [2:0]                 leds,
   input  logic                       ext_rden,
   output logic                       ext_dsr,
   output logic                       busy,
   output logic                       error,
   ps2_led_sequencer_if.master        ps2
);

   localparam logic [19:0] TIMEOUT_C    = 20'(TIMEOUT);
   localparam logic [3:0]  MAX_RETRY_C  = 4'(MAX_RETRY);
   localparam logic [7:0]  CMD_SET_LEDS = 8'hED;
   localparam logic [7:0]  REPLY_ACK    = 8'hFA;
   localparam logic [7:0]  REPLY_RESEND = 8'hFE;
   localparam logic [7:0]  REPLY_BAT_OK = 8'hAA;

   typedef enum logic [3:0] {
      S_IDLE, S_SEND_CMD, S_WAIT_TXC, S_WAIT_ACK1,
      S_SEND_ARG, S_WAIT_TXA, S_WAIT_ACK2, S_RETRY, S_DONE, S_FAIL
   } state_t;

   state_t      state_q, state_d;
   logic        claim_q, claim_d;
   logic        rx_rden_q, rx_rden_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        error_q, error_d;
   logic        dirty_q, dirty_d;
   logic [2:0]  sent_leds_q, sent_leds_d;
   logic [3:0]  retry_q, retry_d;
   logic [19:0] timer_q, timer_d;
   logic        ret_arg_q, ret_arg_d;   // retry returns to SEND_ARG when set
   logic [1:0]  rd_sr_q, rd_sr_d;       // tracks the read pulses of the last 2 cycles

   logic        rd_en;
   logic        reply_vld;
   logic        timeout;
   logic        can_read;
   logic [19:0] timer_inc;
   logic [3:0]  retry_inc;

   // While the port is claimed, the matrix logic sees no data and its read
   // enable is ignored.
   assign rd_en       = claim_q ? rx_rden_q : ext_rden;
   assign ps2.rx_rden = rd_en;
   assign ext_dsr     = claim_q ? 1'b0 : ps2.rx_dsr;
   assign ps2.tx_data  = tx_data_q;
   assign ps2.tx_start = tx_start_q;
   assign busy        = claim_q;
   assign error       = error_q;

   // rx_q holds the byte for the read pulse issued 2 cycles earlier.
   assign reply_vld = rd_sr_q[1];
   assign timeout   = (timer_q == TIMEOUT_C);
   // Only one read may be outstanding at a time.
   assign can_read  = ps2.rx_dsr && !rx_rden_q && (rd_sr_q == 2'b00);
   // The timer saturates, so the timeout event fires only once.
   assign timer_inc = timeout ? timer_q : timer_q + 20'd1;
   assign retry_inc = retry_q + 4'd1;

   // NOTE: each signal gets a default at the top of this block. Then no path
   // through the case statement leaves a signal unassigned, and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      rx_rden_d   = 1'b0;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      error_d     = error_q;
      dirty_d     = dirty_q;
      sent_leds_d = sent_leds_q;
      retry_d     = retry_q;
      timer_d     = timer_q;
      ret_arg_d   = ret_arg_q;
      rd_sr_d     = {rd_sr_q[0], rd_en};

      case (state_q)
         S_IDLE: begin
            // A BAT-passed byte means the keyboard has cleared its LEDs.
            if ((leds != sent_leds_q) || (reply_vld && ps2.rx_q == REPLY_BAT_OK))
               dirty_d = 1'b1;
            // Do not take the port while a matrix read is still in flight.
            if (dirty_q && !ext_rden && rd_sr_q == 2'b00) begin
               sent_leds_d = leds;
               dirty_d     = 1'b0;
               retry_d     = 4'd0;
               state_d     = S_SEND_CMD;
            end
         end
         S_SEND_CMD, S_SEND_ARG: begin
            tx_data_d  = (state_q == S_SEND_CMD) ? CMD_SET_LEDS : {5'b0, sent_leds_q};
            tx_start_d = 1'b1;
            timer_d    = 20'd0;
            state_d    = (state_q == S_SEND_CMD) ? S_WAIT_TXC : S_WAIT_TXA;
         end
         S_WAIT_TXC, S_WAIT_TXA: begin
            timer_d   = timer_inc;
            ret_arg_d = (state_q == S_WAIT_TXA);
            if (ps2.tx_err) begin
               state_d = S_RETRY;
            end else if (ps2.tx_done) begin
               timer_d = 20'd0;
               state_d = (state_q == S_WAIT_TXC) ? S_WAIT_ACK1 : S_WAIT_ACK2;
            end else if (timeout) begin
               state_d = S_RETRY;
            end
         end
         S_WAIT_ACK1, S_WAIT_ACK2: begin
            timer_d   = timer_inc;
            ret_arg_d = (state_q == S_WAIT_ACK2);
            if (reply_vld && ps2.rx_q == REPLY_ACK) begin
               retry_d = 4'd0;
               state_d = (state_q == S_WAIT_ACK1) ? S_SEND_ARG : S_DONE;
            end else if (reply_vld && ps2.rx_q == REPLY_RESEND) begin
               state_d = S_RETRY;
            end else if (timeout) begin
               state_d = S_RETRY;
            end else if (can_read) begin
               // Other bytes are discarded. The timer keeps running.
               rx_rden_d = 1'b1;
            end
         end
         S_RETRY: begin
            retry_d = retry_inc;
            if (retry_inc > MAX_RETRY_C) state_d = S_FAIL;
            else                         state_d = ret_arg_q ? S_SEND_ARG : S_SEND_CMD;
         end
         S_DONE: begin
            error_d = 1'b0;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            // dirty stays clear, so a dead keyboard is not retried endlessly.
            error_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      claim_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only. Every flop
   // then samples its pre-edge value, whatever order the statements are in.
   always_ff @(posedge clkk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         claim_q     <= 1'b0;
         rx_rden_q   <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         error_q     <= 1'b0;
         dirty_q     <= 1'b1;
         sent_leds_q <= 3'b000;
         retry_q     <= 4'd0;
         timer_q     <= 20'd0;
         ret_arg_q   <= 1'b0;
         rd_sr_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         claim_q     <= claim_d;
         rx_rden_q   <= rx_rden_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         error_q     <= error_d;
         dirty_q     <= dirty_d;
         sent_leds_q <= sent_leds_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         ret_arg_q   <= ret_arg_d;
         rd_sr_q     <= rd_sr_d;
      end
   end

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// tb_ps2_led_sequencer
// Bench for ps2_led_sequencer. A keyboard/ps2k responder pops the expected
// transmit bytes from a scoreboard queue and replies as each entry directs.
module tb_ps2_led_sequencer;

   localparam int TIMEOUT   = 40;
   localparam int MAX_RETRY = 3;
   localparam int TX_LAT    = 3;

   logic       clkk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] leds = 3'b000;
   logic       ext_rden = 1'b0;
   logic       ext_dsr, busy, error;

   ps2_led_sequencer_if bus();

   ps2_led_sequencer #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
      .clkk     (clkk),
      .reset    (reset),
      .leds     (leds),
      .ext_rden (ext_rden),
      .ext_dsr  (ext_dsr),
      .busy     (busy),
      .error    (error),
      .ps2      (bus)
   );

   always #5 clkk = ~clkk;

   typedef enum {M_ACK, M_SILENT_RX, M_ERR, M_NO_DONE} mode_e;
   typedef struct {
      logic [7:0] data;
      mode_e      mode;
      logic [7:0] reply;
      bit         noise;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] rx_fifo[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int tx_count = 0;
   int ext_dsr_leak = 0;
   int last_rden_cyc = 0;
   int prev_tx_cyc = 0;
   int last_tx_cyc = 0;

   always @(posedge clkk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void expect_tx(input logic [7:0] d, input mode_e m,
                                     input logic [7:0] r, input bit noise);
      exp_t e;
      e.data = d; e.mode = m; e.reply = r; e.noise = noise;
      sb.push_back(e);
   endfunction

   // Responder. It runs on the falling edge, so the DUT outputs are stable and
   // its own outputs settle well before the next rising edge.
   initial begin : responder
      exp_t       cur;
      int         lat_cnt;
      logic [7:0] rx_p1, rx_p2;
      bit         rx_v1, rx_v2;
      lat_cnt = 0; rx_p1 = 8'h00; rx_p2 = 8'h00; rx_v1 = 0; rx_v2 = 0;
      cur.data = 8'h00; cur.mode = M_ACK; cur.reply = 8'h00; cur.noise = 0;
      bus.rx_dsr = 1'b0; bus.rx_q = 8'h00; bus.tx_done = 1'b0; bus.tx_err = 1'b0;
      forever begin
         @(negedge clkk);
         // ps2k read pipeline: rx_q presents the byte in the 2nd cycle after the pulse
         if (rx_v2) bus.rx_q = rx_p2;
         rx_v2 = rx_v1; rx_p2 = rx_p1; rx_v1 = 0;
         if (bus.rx_rden) begin
            last_rden_cyc = cyc;
            if (rx_fifo.size() != 0) begin
               rx_p1 = rx_fifo.pop_front();
               rx_v1 = 1;
            end
         end
         if (busy && ext_dsr) ext_dsr_leak++;
         bus.tx_done = 1'b0;
         bus.tx_err  = 1'b0;
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               case (cur.mode)
                  M_ACK: begin
                     bus.tx_done = 1'b1;
                     if (cur.noise) rx_fifo.push_back(8'h1C);
                     rx_fifo.push_back(cur.reply);
                  end
                  M_SILENT_RX: bus.tx_done = 1'b1;
                  M_ERR:       bus.tx_err  = 1'b1;
                  default:     ;
               endcase
            end
         end
         if (bus.tx_start) begin
            tx_count++;
            prev_tx_cyc = last_tx_cyc;
            last_tx_cyc = cyc;
            check("tx_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               check("tx_data", 32'(bus.tx_data), 32'(cur.data));
               lat_cnt = TX_LAT;
            end
         end
         bus.rx_dsr = (rx_fifo.size() != 0);
      end
   end

   task automatic tick();
      @(posedge clkk);
      #1;
   endtask

   task automatic wait_busy(input logic lvl, input int budget, input string tag);
      int n = 0;
      while (busy !== lvl && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(busy), 32'(lvl));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     32'(busy),         32'd0);
      check({tag, "_error"},    32'(error),        32'd0);
      check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      check({tag, "_tx_data"},  32'(bus.tx_data),  32'h00);
      check({tag, "_rx_rden"},  32'(bus.rx_rden),  32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int base;
      int n;

      // Reset state, then the power-up sync of LEDs 000
      repeat (3) tick();
      check_reset_outputs("rst");
      expect_tx(8'hED, M_ACK, 8'hFA, 0);
      expect_tx(8'h00, M_ACK, 8'hFA, 0);
      base = tx_count;
      reset = 1'b0;
      wait_busy(1'b1, 10, "t1_start");
      n = 0;
      while (!bus.tx_start && n < 10) begin
         tick();
         n++;
      end
      check("t1_tx_start_lat", 32'(n), 32'd1);
      wait_busy(1'b0, 300, "t1_done");
      check("t1_error", 32'(error), 32'd0);
      check("t1_tx_count", 32'(tx_count - base), 32'd2);
      check("t1_sb_left", 32'(sb.size()), 32'd0);
      check("t1_claim_release", 32'((cyc - last_rden_cyc) <= 4), 32'd1);

      // Caps on: a resend of the argument repeats only the argument
      repeat (5) tick();
      expect_tx(8'hED, M_ACK, 8'hFA, 0);
      expect_tx(8'h04, M_ACK, 8'hFE, 0);
      expect_tx(8'h04, M_ACK, 8'hFA, 0);
      base = tx_count;
      leds = 3'b100;
      wait_busy(1'b1, 10, "t2_start");
      wait_busy(1'b0, 300, "t2_done");
      check("t2_error", 32'(error), 32'd0);
      check("t2_tx_count", 32'(tx_count - base), 32'd3);
      check("t2_sb_left", 32'(sb.size()), 32'd0);

      // Four FE replies to ED exhaust the retries
      repeat (5) tick();
      for (int i = 0; i < 4; i++) expect_tx(8'hED, M_ACK, 8'hFE, 0);
      base = tx_count;
      leds = 3'b001;
      wait_busy(1'b1, 10, "t3_start");
      wait_busy(1'b0, 500, "t3_done");
      check("t3_error", 32'(error), 32'd1);
      check("t3_tx_count", 32'(tx_count - base), 32'd4);
      base = tx_count;
      repeat (60) tick();
      check("t3_quiet", 32'(tx_count - base), 32'd0);
      check("t3_busy_idle", 32'(busy), 32'd0);

      // Transmit error, then a stray scancode ahead of the ACK
      expect_tx(8'hED, M_ERR,  8'h00, 0);
      expect_tx(8'hED, M_ACK,  8'hFA, 1);
      expect_tx(8'h03, M_ACK,  8'hFA, 0);
      base = tx_count;
      leds = 3'b011;
      wait_busy(1'b1, 10, "t4_start");
      wait_busy(1'b0, 300, "t4_done");
      check("t4_error", 32'(error), 32'd0);
      check("t4_tx_count", 32'(tx_count - base), 32'd3);
      check("t4_sb_left", 32'(sb.size()), 32'd0);
      check("t4_fifo_empty", 32'(rx_fifo.size()), 32'd0);

      // Matrix reads BAT-passed AA: the LEDs are resent
      repeat (5) tick();
      expect_tx(8'hED, M_ACK, 8'hFA, 0);
      expect_tx(8'h03, M_ACK, 8'hFA, 0);
      rx_fifo.push_back(8'hAA);
      tick();
      tick();
      check("t5_ext_dsr", 32'(ext_dsr), 32'd1);
      ext_rden = 1'b1;
      #1;
      check("t5_rden_pass", 32'(bus.rx_rden), 32'd1);
      tick();
      ext_rden = 1'b0;
      n = 1;
      while (!busy && n < 10) begin
         tick();
         n++;
      end
      check("t5_aa_lat", 32'(n <= 4), 32'd1);
      wait_busy(1'b0, 300, "t5_done");
      check("t5_sb_left", 32'(sb.size()), 32'd0);

      // No tx_done: the timeout forces a resend of ED
      repeat (5) tick();
      expect_tx(8'hED, M_NO_DONE, 8'h00, 0);
      expect_tx(8'hED, M_ACK, 8'hFA, 0);
      expect_tx(8'h07, M_ACK, 8'hFA, 0);
      base = tx_count;
      leds = 3'b111;
      n = 0;
      while (tx_count - base < 2 && n < 200) begin
         tick();
         n++;
      end
      check("t5_timeout_gap", 32'(last_tx_cyc - prev_tx_cyc), 32'(TIMEOUT + 3));
      wait_busy(1'b0, 300, "t5b_done");
      check("t5b_error", 32'(error), 32'd0);
      check("t5b_sb_left", 32'(sb.size()), 32'd0);

      // Reset while waiting for the second ACK
      repeat (5) tick();
      expect_tx(8'hED, M_ACK, 8'hFA, 0);
      expect_tx(8'h02, M_SILENT_RX, 8'h00, 0);
      base = tx_count;
      leds = 3'b010;
      n = 0;
      while (tx_count - base < 2 && n < 200) begin
         tick();
         n++;
      end
      repeat (8) tick();
      check("t6_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      check_reset_outputs("t6_rst");
      repeat (3) tick();
      check("t6_no_tx", 32'(tx_count - base), 32'd2);
      expect_tx(8'hED, M_ACK, 8'hFA, 0);
      expect_tx(8'h02, M_ACK, 8'hFA, 0);
      base = tx_count;
      reset = 1'b0;
      wait_busy(1'b1, 10, "t6_start");
      wait_busy(1'b0, 300, "t6_done");
      check("t6_error", 32'(error), 32'd0);
      check("t6_tx_count", 32'(tx_count - base), 32'd2);
      check("t6_sb_left", 32'(sb.size()), 32'd0);
      check("ext_dsr_leak", 32'(ext_dsr_leak), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_led_sequencer.md
Name: ps2_led_sequencer

Overview:
- Host-to-keyboard command sequencer that keeps the PS/2 keyboard LEDs in step with machine state (RUS mode on Caps Lock LED).
- Issues the ED + argument command pair through the PS/2 transmitter and consumes the keyboard's ACK/RESEND replies.
- Arbitrates the shared ps2k receive read port between itself and the keyboard matrix logic, so reply bytes never reach the matrix.
- Sits between the ps2k driver and the vectorkeys matrix logic.

Parameters:
- TIMEOUT, 600000, cycles to wait for tx_done or a reply byte (about 25 ms at 24 MHz); counter is 20 bits.
- MAX_RETRY, 3, resends allowed per byte before failure.

Ports:
- clkk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- leds  in  3  requested LED state: [0] Scroll, [1] Num, [2] Caps (driven by mod_rus)
- rx_dsr  in  1  ps2k byte available
- rx_q  in  8  ps2k byte; valid 2 cycles after a read-enable pulse
- rx_rden  out  1  read enable to ps2k
- ext_rden  in  1  read enable from matrix logic
- ext_dsr  out  1  byte-available indication to matrix logic
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_done  in  1  one-cycle pulse, byte sent
- tx_err  in  1  one-cycle pulse, transmit failed
- busy  out  1  transaction in progress
- error  out  1  sticky: last transaction failed

Behaviour:
- Reset values: rx_rden=0, tx_start=0, tx_data=00, busy=0, error=0, claim=0, state=IDLE, retry=0, timer=0. dirty=1, so LEDs sync after reset. sent_leds=000.
- Reset mid-transaction aborts immediately. No further tx_start is issued. A pending rx byte is left in ps2k.

Port arbitration:
- claim=1 in every state except IDLE.
- claim=0: rx_rden=ext_rden, ext_dsr=rx_dsr.
- claim=1: rx_rden=own pulse, ext_dsr=0, ext_rden ignored.

Snoop and dirty tracking:
- In IDLE, 2 cycles after an ext_rden pulse, if rx_q=AA (keyboard BAT passed), set dirty. The keyboard has cleared its LEDs.
- Set dirty whenever leds != sent_leds, sampled every cycle in IDLE.

States:
- IDLE: if dirty and no ext_rden in flight (no ext_rden in the last 2 cycles), latch arg={5'b0,leds}, sent_leds=leds, clear dirty, retry=0, go SEND_CMD.
- SEND_CMD: tx_data=ED, tx_start=1 for one cycle, timer=0, go WAIT_TXC.
- WAIT_TXC: on tx_done, go WAIT_ACK1 with timer=0. On tx_err or timeout, take the RETRY path with return state SEND_CMD.
- WAIT_ACK1: when rx_dsr=1, pulse rx_rden. Evaluate rx_q 2 cycles later. While awaiting rx_q, no new pulse is issued.
  - FA: go SEND_ARG.
  - FE: RETRY to SEND_CMD.
  - Any other byte: discard and keep waiting; timer not reset.
  - Timeout: RETRY to SEND_CMD.
- SEND_ARG, WAIT_TXA, WAIT_ACK2: identical to the ED path, but send arg. A retry resends arg only. FA in WAIT_ACK2 goes DONE.
- RETRY: retry+1. If the new value exceeds MAX_RETRY, go FAIL; otherwise go to the return state.
- DONE: error=0, go IDLE.
- FAIL: error=1, go IDLE. dirty stays 0, so there is no hammering; the next LED change or AA retries.
- busy=1 outside IDLE.

Timing and boundaries:
- tx_start is issued the cycle after entering a SEND state, so IDLE→tx_start takes 2 cycles.
- tx_done and tx_err in the same cycle: tx_err wins.
- rx_dsr high on the IDLE→SEND_CMD cycle: the byte stays for the matrix only after release (claim already set).
- leds changing during a transaction: sent_leds mismatch sets dirty at IDLE return; exactly one follow-up transaction.
- Timer saturates at TIMEOUT; the timeout event fires once.

Test Plan:
- Release reset; leds=000. Expect: tx_start with ED; tx_done; rx FA; tx_start with 00; tx_done; FA. Then busy=0, error=0, exactly 2 tx_start pulses, ext_dsr=0 throughout, total claim time ends ≤2 cycles after the last FA read.
- From idle, leds 000→100. Expect: ED then 04 sent. FE reply to 04 causes 04 resent (not ED); then FA ends in DONE.
- Reply FE 4 times to ED. Expect: 4 ED transmissions (1+3 retries), then error=1, busy=0, no further tx_start until leds change.
- Inject byte 1C (scancode) while in WAIT_ACK1, then FA. Expect: 1C consumed internally, ext_dsr stays 0, sequence continues to arg.
- While idle, matrix reads AA via ext_rden. Expect: new ED+sent_leds transaction starts within 4 cycles. No tx_done for TIMEOUT cycles causes a retry.
- Assert reset during WAIT_ACK2. Expect: all outputs at reset values next cycle; after release, a fresh ED sequence starts (dirty=1).
